led_pattern_gen: RTL and testbench

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

---
 rtl/led_pattern_gen.sv | 148 ++++++++++++++
 tb/tb_led_pattern_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// led_pattern_gen
// ---------------
// Drives a bank of LEDs with one of four animated patterns (BLINK, SHIFT,
// BOUNCE, COUNT). A programmable down-counter prescaler sets how often the
// pattern advances. A requested mode is adopted only on a step.
//
// Ports
//    sys_clk      : single clock, all state changes on its rising edge
//    sys_rst      : synchronous active-high reset
//    enable       : 1 = run, 0 = freeze prescaler, LEDs, mode and direction
//    period       : prescaler reload value, step interval is period+1 cycles
//    mode         : requested pattern (0 BLINK, 1 SHIFT, 2 BOUNCE, 3 COUNT)
//    led          : registered LED pattern
//    tick         : registered, high for the one cycle after each step
//    mode_active  : registered, the pattern currently being applied

module led_pattern_gen #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 23
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             enable,
   input  logic [CNT_W-1:0] period,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] led,
   output logic             tick,
   output logic [1:0]       mode_active
);

   typedef enum logic [1:0] {
      MODE_BLINK  = 2'd0,
      MODE_SHIFT  = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_COUNT  = 2'd3
   } modeE;

   // Alternating bit pattern anchored so that the MSB is always set,
   // which keeps the look consistent for odd widths too.
   function automatic logic [WIDTH-1:0] blinkInit();
      logic [WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH; i++) begin
         r[i] = (((WIDTH - 1 - i) % 2) == 0);
      end
      return r;
   endfunction

   localparam logic [WIDTH-1:0] BLINK_INIT = blinkInit();
   localparam logic [WIDTH-1:0] LED_ONE    = WIDTH'(1);

   logic [CNT_W-1:0] cntQ, cntD;
   logic [WIDTH-1:0] ledQ, ledD;
   modeE             modeQ, modeD;
   logic             dirUpQ, dirUpD;
   logic             tickQ, tickD;

   logic             ledOneHot;
   modeE             modeReq;

   assign modeReq   = modeE'(mode);

   // A pattern is one-hot when it is non-zero and clearing its lowest set
   // bit leaves nothing behind.
   assign ledOneHot = (ledQ != '0) && ((ledQ & (ledQ - LED_ONE)) == '0);

   // Next-state logic. A step happens on an enabled cycle with the
   // prescaler at zero. That step either adopts a new mode (loading its
   // starting pattern) or advances the current pattern, never both.
   always_comb begin
      cntD   = cntQ;
      ledD   = ledQ;
      modeD  = modeQ;
      dirUpD = dirUpQ;
      tickD  = 1'b0;

      if (enable) begin
         if (cntQ == '0) begin
            cntD  = period;
            tickD = 1'b1;
            if (modeReq != modeQ) begin
               modeD  = modeReq;
               dirUpD = 1'b1;
               case (modeReq)
                  MODE_BLINK:  ledD = BLINK_INIT;
                  MODE_SHIFT:  ledD = LED_ONE;
                  MODE_BOUNCE: ledD = LED_ONE;
                  MODE_COUNT:  ledD = '0;
               endcase
            end else begin
               case (modeQ)
                  MODE_BLINK:  ledD = ~ledQ;
                  MODE_SHIFT:  ledD = {ledQ[WIDTH-2:0], ledQ[WIDTH-1]};
                  MODE_BOUNCE: begin
                     // Anything other than a single lit LED restarts
                     // the bounce from bit0 heading up. The ends turn
                     // around immediately, without a repeated position.
                     if (!ledOneHot) begin
                        ledD   = LED_ONE;
                        dirUpD = 1'b1;
                     end else if (dirUpQ) begin
                        if (ledQ[WIDTH-1]) begin
                           ledD   = ledQ >> 1;
                           dirUpD = 1'b0;
                        end else begin
                           ledD = ledQ << 1;
                        end
                     end else begin
                        if (ledQ[0]) begin
                           ledD   = ledQ << 1;
                           dirUpD = 1'b1;
                        end else begin
                           ledD = ledQ >> 1;
                        end
                     end
                  end
                  MODE_COUNT:  ledD = ledQ + LED_ONE;
               endcase
            end
         end else begin
            cntD = cntQ - CNT_W'(1);
         end
      end
   end

   // State registers. Reset leaves the prescaler at zero so that the first
   // enabled cycle afterwards is a step.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cntQ   <= '0;
         ledQ   <= BLINK_INIT;
         modeQ  <= MODE_BLINK;
         dirUpQ <= 1'b1;
         tickQ  <= 1'b0;
      end else begin
         cntQ   <= cntD;
         ledQ   <= ledD;
         modeQ  <= modeD;
         dirUpQ <= dirUpD;
         tickQ  <= tickD;
      end
   end

   assign led         = ledQ;
   assign tick        = tickQ;
   assign mode_active = modeQ;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen
// ------------------
// Bench for led_pattern_gen at WIDTH=8. It uses a constant vector table,
// hand-written multi-cycle sequences and randomized stimulus checked
// against a behavioural model.

module tb_led_pattern_gen;

   localparam int W  = 8;
   localparam int CW = 23;

   logic          sys_clk;
   logic          sys_rst;
   logic          enable;
   logic [CW-1:0] period;
   logic [1:0]    mode;
   logic [W-1:0]  led;
   logic          tick;
   logic [1:0]    mode_active;

   int totalCnt;
   int badCnt;

   // Behavioural model state
   logic [7:0] mLed;
   logic       mTick;
   logic [1:0] mMode;
   int         mCnt;
   logic       mUp;

   typedef struct {
      logic          rst;
      logic          en;
      logic [CW-1:0] per;
      logic [1:0]    md;
      logic [7:0]    expLed;
      logic          expTick;
      logic [1:0]    expMode;
   } vecT;

   vecT        vecs[13];
   logic [7:0] bounceSeq[16];

   led_pattern_gen #(.WIDTH(W), .CNT_W(CW)) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .enable      (enable),
      .period      (period),
      .mode        (mode),
      .led         (led),
      .tick        (tick),
      .mode_active (mode_active)
   );

   // Free-running clock, 10 time units per period
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Model of one clock edge, worked out from the pattern rules:
   // blink = complement, shift = multiply by two with the top bit carried
   // around, bounce = position index walking between 0 and 7,
   // count = increment modulo 256.
   task automatic modelStep(input logic r, input logic e,
                            input logic [CW-1:0] p, input logic [1:0] m);
      int v;
      int pos;
      int ones;
      if (r) begin
         mLed  = 8'hAA;
         mTick = 1'b0;
         mMode = 2'd0;
         mCnt  = 0;
         mUp   = 1'b1;
      end else if (!e) begin
         mTick = 1'b0;
      end else if (mCnt == 0) begin
         mTick = 1'b1;
         mCnt  = int'(p);
         if (m != mMode) begin
            mMode = m;
            mUp   = 1'b1;
            case (m)
               2'd0:    mLed = 8'hAA;
               2'd3:    mLed = 8'h00;
               default: mLed = 8'h01;
            endcase
         end else begin
            v = int'(mLed);
            case (mMode)
               2'd0: mLed = 8'(255 - v);
               2'd1: mLed = 8'(((v * 2) % 256) + (v / 128));
               2'd2: begin
                  ones = 0;
                  pos  = 0;
                  for (int b = 0; b < 8; b++) begin
                     if (mLed[b]) begin
                        ones++;
                        pos = b;
                     end
                  end
                  if (ones != 1) begin
                     pos = 0;
                     mUp = 1'b1;
                  end else if (mUp) begin
                     if (pos == 7) begin
                        pos = 6;
                        mUp = 1'b0;
                     end else begin
                        pos = pos + 1;
                     end
                  end else begin
                     if (pos == 0) begin
                        pos = 1;
                        mUp = 1'b1;
                     end else begin
                        pos = pos - 1;
                     end
                  end
                  mLed = 8'(1 << pos);
               end
               default: mLed = 8'((v + 1) % 256);
            endcase
         end
      end else begin
         mCnt  = mCnt - 1;
         mTick = 1'b0;
      end
   endtask

   // Drive one cycle of inputs, advance the model, and let one edge pass.
   // Outputs are then sampled 1 time unit after the edge.
   task automatic applyStimulus(input logic r, input logic e,
                                input logic [CW-1:0] p, input logic [1:0] m);
      sys_rst = r;
      enable  = e;
      period  = p;
      mode    = m;
      modelStep(r, e, p, m);
      @(posedge sys_clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] expL,
                              input logic expT, input logic [1:0] expM);
      totalCnt++;
      if (led !== expL || tick !== expT || mode_active !== expM) begin
         badCnt++;
         $display("[TB] FAIL %s: got led=%h tick=%b mode=%0d, want led=%h tick=%b mode=%0d",
                  name, led, tick, mode_active, expL, expT, expM);
      end
   endtask

   initial begin
      logic [7:0] cntExp;
      logic       r;
      logic       e;
      logic [CW-1:0] p;
      logic [1:0] m;
      logic       expT;

      totalCnt = 0;
      badCnt   = 0;
      sys_rst  = 1'b1;
      enable   = 1'b0;
      period   = '0;
      mode     = 2'd0;
      mLed     = 8'hAA;
      mTick    = 1'b0;
      mMode    = 2'd0;
      mCnt     = 0;
      mUp      = 1'b1;

      // Blink start-up, a mode change to SHIFT, freeze, and a reset
      vecs[0]  = '{1'b1, 1'b0, 23'd3, 2'd0, 8'hAA, 1'b0, 2'd0};
      vecs[1]  = '{1'b0, 1'b1, 23'd3, 2'd0, 8'h55, 1'b1, 2'd0};
      vecs[2]  = '{1'b0, 1'b1, 23'd3, 2'd0, 8'h55, 1'b0, 2'd0};
      vecs[3]  = '{1'b0, 1'b1, 23'd3, 2'd0, 8'h55, 1'b0, 2'd0};
      vecs[4]  = '{1'b0, 1'b1, 23'd3, 2'd0, 8'h55, 1'b0, 2'd0};
      vecs[5]  = '{1'b0, 1'b1, 23'd3, 2'd0, 8'hAA, 1'b1, 2'd0};
      vecs[6]  = '{1'b0, 1'b1, 23'd0, 2'd1, 8'hAA, 1'b0, 2'd0};
      vecs[7]  = '{1'b0, 1'b1, 23'd0, 2'd1, 8'hAA, 1'b0, 2'd0};
      vecs[8]  = '{1'b0, 1'b1, 23'd0, 2'd1, 8'hAA, 1'b0, 2'd0};
      vecs[9]  = '{1'b0, 1'b1, 23'd0, 2'd1, 8'h01, 1'b1, 2'd1};
      vecs[10] = '{1'b0, 1'b1, 23'd0, 2'd1, 8'h02, 1'b1, 2'd1};
      vecs[11] = '{1'b0, 1'b0, 23'd0, 2'd1, 8'h02, 1'b0, 2'd1};
      vecs[12] = '{1'b1, 1'b1, 23'd0, 2'd1, 8'hAA, 1'b0, 2'd0};

      bounceSeq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                    8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

      $display("[TB] vector table");
      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].per, vecs[i].md);
         checkOutput($sformatf("vec%0d", i), vecs[i].expLed, vecs[i].expTick, vecs[i].expMode);
      end

      $display("[TB] shift full rotation");
      applyStimulus(1'b1, 1'b0, 23'd0, 2'd1);
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b0, 1'b1, 23'd0, 2'd1);
         cntExp = 8'(1 << (i % 8));
         checkOutput("shift", cntExp, 1'b1, 2'd1);
      end

      $display("[TB] bounce sequence");
      applyStimulus(1'b1, 1'b0, 23'd0, 2'd2);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b1, 23'd0, 2'd2);
         checkOutput("bounce", bounceSeq[i], 1'b1, 2'd2);
      end

      $display("[TB] count with enable drop and wrap");
      applyStimulus(1'b1, 1'b0, 23'd0, 2'd3);
      cntExp = 8'h00;
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b0, 1'b1, 23'd0, 2'd3);
         checkOutput("count", cntExp, 1'b1, 2'd3);
         cntExp = cntExp + 8'd1;
      end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 23'd0, 2'd3);
         checkOutput("count_hold", 8'h10, 1'b0, 2'd3);
      end
      for (int i = 0; i < 240; i++) begin
         applyStimulus(1'b0, 1'b1, 23'd0, 2'd3);
         checkOutput("count_run", cntExp, 1'b1, 2'd3);
         cntExp = cntExp + 8'd1;
      end

      $display("[TB] period change mid-interval, then reset mid-interval");
      applyStimulus(1'b1, 1'b0, 23'd9, 2'd1);
      for (int c = 1; c <= 15; c++) begin
         p    = (c >= 5) ? 23'd1 : 23'd9;
         expT = (c == 1) || (c == 11) || (c == 13) || (c == 15);
         applyStimulus(1'b0, 1'b1, p, 2'd1);
         checkOutput("period", mLed, expT, 2'd1);
      end
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b0, 1'b1, 23'd9, 2'd1);
      end
      applyStimulus(1'b1, 1'b1, 23'd9, 2'd1);
      checkOutput("mid_reset", 8'hAA, 1'b0, 2'd0);

      $display("[TB] mode toggle between steps");
      applyStimulus(1'b1, 1'b0, 23'd3, 2'd0);
      applyStimulus(1'b0, 1'b1, 23'd3, 2'd0);
      checkOutput("toggle_first", 8'h55, 1'b1, 2'd0);
      applyStimulus(1'b0, 1'b1, 23'd3, 2'd2);
      checkOutput("toggle_mid", 8'h55, 1'b0, 2'd0);
      applyStimulus(1'b0, 1'b1, 23'd3, 2'd2);
      applyStimulus(1'b0, 1'b1, 23'd3, 2'd0);
      applyStimulus(1'b0, 1'b1, 23'd3, 2'd0);
      checkOutput("toggle_step", 8'hAA, 1'b1, 2'd0);

      $display("[TB] randomized run against model");
      applyStimulus(1'b1, 1'b0, 23'd0, 2'd0);
      m = 2'd0;
      for (int i = 0; i < 2000; i++) begin
         r = ($urandom_range(0, 99) < 2);
         e = ($urandom_range(0, 9) != 0);
         p = CW'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) begin
            m = 2'($urandom_range(0, 3));
         end
         applyStimulus(r, e, p, m);
         checkOutput("random", mLed, mTick, mMode);
      end

      $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
      $finish;
   end

endmodule
